// File: rtl/csr_mem_pkg.sv
// csr_mem_pkg: register address codes and handshake state encoding shared with the memory controller
package csr_mem_pkg;
    localparam logic [1:0] MSIP     = 2'b00;
    localparam logic [1:0] MTIME    = 2'b10;
    localparam logic [1:0] MTIMECMP = 2'b11;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACK  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
endpackage

// File: rtl/mtime_prescaler.sv
// mtime_prescaler: emits a one-cycle tick every TICK_DIV clocks, restartable by clear
module mtime_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic clear,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);
    logic [15:0] cnt;
    assign tick = cnt == LAST;
    // wrap at the end of each period; a direct mtime write restarts the period
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) cnt <= '0;
        else cnt <= (clear || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/csr_mem.sv
// csr_mem: msip/mtime/mtimecmp register block with one-cycle acknowledge handshake
module csr_mem
    import csr_mem_pkg::*;
#(
    parameter int BYTE_AMNT = 8,
    parameter int TICK_DIV  = 1
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [2:0]               addr,
    input  logic [8*BYTE_AMNT-1:0]   wr_data,
    output logic [8*BYTE_AMNT-1:0]   rd_data,
    output logic                     mem_ack,
    output logic                     msip,
    output logic                     mtip,
    output logic [63:0]              mtime_o
);
    localparam int W = 8 * BYTE_AMNT;
    logic [1:0]   state;
    logic [63:0]  mtime, mtimecmp, wd, rval;
    logic [31:0]  half;
    logic [W-1:0] rd_next;
    logic         busy, req, wr, mt_wr, tick;
    assign busy    = rd_en || wr_en;
    assign req     = state == IDLE && busy;
    assign wr      = req && wr_en;
    assign mt_wr   = wr && addr[1:0] == MTIME;
    assign wd      = 64'(wr_data);
    assign rval    = addr[1:0] == MSIP ? {63'b0, msip} : addr[1:0] == MTIME ? mtime :
                     addr[1:0] == MTIMECMP ? mtimecmp : 64'b0;
    assign half    = addr[2] ? rval[63:32] : rval[31:0];
    assign rd_next = W'(BYTE_AMNT == 8 ? rval : {32'b0, half});
    assign mem_ack = state == ACK;
    assign mtime_o = mtime;
    // on a 32-bit bus only the half selected by addr[2] is replaced
    function automatic logic [63:0] merge(input logic [63:0] old);
        return BYTE_AMNT == 8 ? wd : addr[2] ? {wd[31:0], old[31:0]} : {old[63:32], wd[31:0]};
    endfunction
    mtime_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .clear(mt_wr),
        .tick (tick)
    );
    // commit bus writes; a write to mtime overrides a coincident tick
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            mtime    <= '0;
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (mt_wr) mtime <= merge(mtime);
            else if (tick) mtime <= mtime + 64'd1;
            if (wr && addr[1:0] == MTIMECMP) mtimecmp <= merge(mtimecmp);
            if (wr && addr[1:0] == MSIP) msip <= wr_data[0];
        end
    // compare current register values, so mtip trails them by one cycle
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) mtip <= 1'b0;
        else mtip <= mtime >= mtimecmp;
    // handshake: accept only in IDLE, ack one cycle, then wait for the enables to drop
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            state   <= IDLE;
            rd_data <= '0;
        end else begin
            if (req && rd_en) rd_data <= wr_en ? '0 : rd_next;
            state <= state == IDLE ? (busy ? ACK : IDLE) : (busy ? WAIT : IDLE);
        end
endmodule

// File: tb/tb_csr_mem.sv
// tb_csr_mem: randomized scoreboard bench for an RV64 (TICK_DIV=1) and an RV32 (TICK_DIV=3) instance
module tb_csr_mem;
    typedef struct {
        int          inst;
        int          cyc;
        logic [63:0] data;
    } exp_t;
    logic        clk = 0, rst = 1;
    logic [1:0]  rd_en = 0, wr_en = 0;
    logic [2:0]  addr [2];
    logic [63:0] wd [2];
    logic [63:0] rd0, mto0, mto1;
    logic [31:0] rd1;
    logic [1:0]  ack, msip, mtip;
    int          ecnt = 0, nvec = 0, nfail = 0;
    exp_t        sbq [$];
    logic [63:0] mbase [2], pbase [2], cmpc [2], cmpp [2], lastrd [2];
    int          mk0 [2], pk0 [2], ck [2], sk [2];
    logic        msc [2], msp [2];

    csr_mem #(.BYTE_AMNT(8), .TICK_DIV(1)) dut (
        .CLK_I(clk), .RST_I(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .addr(addr[0]),
        .wr_data(wd[0]), .rd_data(rd0), .mem_ack(ack[0]), .msip(msip[0]), .mtip(mtip[0]), .mtime_o(mto0)
    );
    csr_mem #(.BYTE_AMNT(4), .TICK_DIV(3)) dut32 (
        .CLK_I(clk), .RST_I(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .addr(addr[1]),
        .wr_data(wd[1][31:0]), .rd_data(rd1), .mem_ack(ack[1]), .msip(msip[1]), .mtip(mtip[1]), .mtime_o(mto1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= rst ? 0 : ecnt + 1;

    function automatic int td(input int i);
        return i == 0 ? 1 : 3;
    endfunction
    // mtime after e edges: value of the latest write plus whole prescaler periods elapsed since it
    function automatic logic [63:0] mt_at(input int i, input int e);
        return e >= mk0[i] ? mbase[i] + 64'((e - mk0[i]) / td(i)) : pbase[i] + 64'((e - pk0[i]) / td(i));
    endfunction
    function automatic logic [63:0] cmp_at(input int i, input int e);
        return e >= ck[i] ? cmpc[i] : cmpp[i];
    endfunction
    function automatic logic ms_at(input int i, input int e);
        return e >= sk[i] ? msc[i] : msp[i];
    endfunction
    function automatic logic [63:0] rdval(input int i, input logic [2:0] a, input int e);
        logic [63:0] r;
        r = a[1:0] == 2'b00 ? {63'b0, ms_at(i, e)} : a[1:0] == 2'b10 ? mt_at(i, e) :
            a[1:0] == 2'b11 ? cmp_at(i, e) : 64'b0;
        return i == 0 ? r : {32'b0, a[2] ? r[63:32] : r[31:0]};
    endfunction
    function automatic logic [63:0] merge(input int i, input logic [2:0] a, input logic [63:0] old, input logic [63:0] d);
        return i == 0 ? d : a[2] ? {d[31:0], old[31:0]} : {old[63:32], d[31:0]};
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s[%0d] @%0d: got %h expected %h", nm, i, ecnt, got, exp);
        end
    endtask

    // monitor: every cycle compares state outputs; on each ack pops and checks the scoreboard
    always @(negedge clk)
        if (!rst)
            for (int i = 0; i < 2; i++) begin
                int e, j;
                e = ecnt;
                j = -1;
                chk("mtime", i, i == 0 ? mto0 : mto1, mt_at(i, e));
                chk("msip", i, 64'(msip[i]), 64'(ms_at(i, e)));
                chk("mtip", i, 64'(mtip[i]), e == 0 ? 64'd0 : 64'(mt_at(i, e - 1) >= cmp_at(i, e - 1)));
                if (ack[i]) begin
                    foreach (sbq[n]) if (j < 0 && sbq[n].inst == i) j = n;
                    if (j < 0) chk("spurious_ack", i, 64'd1, 64'd0);
                    else begin
                        chk("ack_cycle", i, 64'(e), 64'(sbq[j].cyc));
                        chk("rd_data", i, i == 0 ? rd0 : {32'b0, rd1}, sbq[j].data);
                        sbq.delete(j);
                    end
                end
            end

    task automatic do_reset();
        rst = 1;
        rd_en = 0;
        wr_en = 0;
        for (int i = 0; i < 2; i++) begin
            mbase[i] = 0; pbase[i] = 0; mk0[i] = 0; pk0[i] = 0;
            cmpc[i] = '1; cmpp[i] = '1; ck[i] = 0;
            msc[i] = 0; msp[i] = 0; sk[i] = 0; lastrd[i] = 0;
        end
        sbq.delete();
        @(negedge clk);
        chk("rst_ack", 0, 64'(ack), 64'd0);
        chk("rst_mtime", 0, mto0 | mto1, 64'd0);
        chk("rst_rd_data", 0, rd0 | 64'(rd1), 64'd0);
        chk("rst_irq", 0, 64'({msip, mtip}), 64'd0);
        @(negedge clk);
        rst = 0;
    endtask

    // one bus access issued from a negedge while the instance is idle; h extra cycles of holding after ack
    task automatic access(input int i, input logic r, input logic w, input logic [2:0] a, input logic [63:0] d, input int h);
        int k;
        exp_t x;
        logic [63:0] rv, nv;
        bit got;
        k = ecnt;
        got = 0;
        rv = w ? 64'd0 : rdval(i, a, k);
        x.inst = i;
        x.cyc = k + 1;
        x.data = r ? rv : lastrd[i];
        if (r) lastrd[i] = rv;
        sbq.push_back(x);
        if (w && a[1:0] == 2'b00) begin
            msp[i] = ms_at(i, k); msc[i] = d[0]; sk[i] = k + 1;
        end
        if (w && a[1:0] == 2'b10) begin
            nv = merge(i, a, mt_at(i, k), d);
            pbase[i] = mbase[i]; pk0[i] = mk0[i]; mbase[i] = nv; mk0[i] = k + 1;
        end
        if (w && a[1:0] == 2'b11) begin
            nv = merge(i, a, cmp_at(i, k), d);
            cmpp[i] = cmpc[i]; cmpc[i] = nv; ck[i] = k + 1;
        end
        rd_en[i] = r;
        wr_en[i] = w;
        addr[i] = a;
        wd[i] = d;
        for (int n = 0; n < 4 && !got; n++) begin
            @(negedge clk);
            got = ack[i];
        end
        if (!got) chk("ack_timeout", i, 64'd0, 64'd1);
        repeat (h) @(negedge clk);
        rd_en[i] = 0;
        wr_en[i] = 0;
        @(negedge clk);
    endtask

    task automatic rand_traffic(input int i);
        for (int n = 0; n < 250; n++) begin
            int op;
            logic [2:0] a;
            logic [63:0] d;
            op = $urandom_range(0, 3);
            a = 3'($urandom_range(0, 7));
            d = $urandom_range(0, 1) ? {$urandom, $urandom} : mt_at(i, ecnt) + 64'($urandom_range(0, 12));
            access(i, op != 2, op >= 2, a, d, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        addr[0] = 0; addr[1] = 0; wd[0] = 0; wd[1] = 0;
        do_reset();
        repeat (10) @(negedge clk);
        chk("idle_mtime", 0, mto0, 64'd10);
        chk("idle_mtime", 1, mto1, 64'd3);
        fork
            begin
                access(0, 0, 1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 0);
                repeat (3) @(negedge clk);
                access(0, 0, 1, 3'b010, 64'd0, 0);
                access(0, 0, 1, 3'b011, 64'd5, 0);
                repeat (8) @(negedge clk);
                access(0, 0, 1, 3'b011, '1, 0);
                access(0, 1, 0, 3'b000, 64'd0, 4);
                access(0, 1, 1, 3'b000, 64'd1, 0);
                access(0, 1, 0, 3'b000, 64'd0, 0);
                access(0, 1, 0, 3'b011, 64'd0, 0);
            end
            begin
                access(1, 0, 1, 3'b110, 64'd1, 0);
                access(1, 0, 1, 3'b010, 64'd0, 0);
                access(1, 1, 0, 3'b111, 64'd0, 0);
                access(1, 1, 0, 3'b011, 64'd0, 1);
            end
        join
        fork
            rand_traffic(0);
            rand_traffic(1);
        join
        sbq.push_back(exp_t'{0, ecnt + 1, rdval(0, 3'b000, ecnt)});
        addr[0] = 3'b000;
        rd_en[0] = 1;
        @(negedge clk);
        chk("ack_before_rst", 0, 64'(ack[0]), 64'd1);
        #2 rst = 1;
        #1 chk("ack_in_rst", 0, 64'(ack[0]), 64'd0);
        do_reset();
        access(0, 1, 0, 3'b010, 64'd0, 0);
        access(1, 1, 0, 3'b011, 64'd0, 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 0, 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
